quad_iter: RTL and testbench
============================

QUAD_ITER -- requirements
Module: quad_iter

Parameters
REQ-001 CAP_OFS, default 8: frame cycle (fc) of the first result word on R; legal range 5..15.
REQ-002 LAG, default 1: frames from a slot's issue to its result; legal range 1..3.

Interface
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 seed_valid  input  1  seed offered.
REQ-006 seed_ready  output  1  seed accepted when both high.
REQ-007 seed_data  input  160  initial 160-bit message; bits 159:128 are word 0.
REQ-008 seed_iters  input  32  number of hash passes, 0 allowed.
REQ-009 out_valid  output  1  finished job available.
REQ-010 out_ready  input  1  consumer takes job when both high.
REQ-011 out_data  output  160  final digest; word 0 in bits 159:128.
REQ-012 out_tag  output  2  slot index of presented job.
REQ-013 phase_advance  output  1  frame strobe to hash pipeline.
REQ-014 Din  output  32  message words to hash pipeline.
REQ-015 R  input  32  result words from hash pipeline; zero outside bursts.

Function
REQ-016 Frame counter fc SHALL count 0..19 and wrap; slot pointer sp (2 bits) SHALL increment when fc wraps 19->0.
REQ-017 phase_advance SHALL be high exactly in cycles with fc==18.
REQ-018 At fc 0..4, Din SHALL carry words 0..4 of slot sp's buffer if slot sp is BUSY; otherwise Din SHALL be 0.
REQ-019 Din SHALL be 0 at fc 5..19.
REQ-020 Issuing slot sp at fc 0 SHALL set its inflight flag.
REQ-021 Capture slot c=(sp-LAG) mod 4: if c inflight, R at fc CAP_OFS+k, k=0..4, SHALL be written to word k of buffer c.
REQ-022 After word 4 is captured, inflight(c) SHALL clear and iters(c) SHALL decrement; at 0 the slot SHALL go DONE, else stay BUSY.
REQ-023 A BUSY slot SHALL be reissued at its next sp frame using the captured words.
REQ-024 Slot states SHALL be IDLE, BUSY, DONE; there SHALL be no other transitions: IDLE->BUSY or DONE on seed accept, BUSY->DONE per REQ-022, DONE->IDLE on output handshake.
REQ-025 seed_ready SHALL be high iff an IDLE slot exists, excluding slot sp while fc is 0..4.
REQ-026 An accepted seed SHALL go to the lowest-indexed eligible IDLE slot.
REQ-027 seed_iters==0 SHALL place the slot directly in DONE with buffer = seed_data.
REQ-028 seed_iters>0 SHALL place the slot in BUSY with iters = seed_iters.
REQ-029 out_valid SHALL be high iff any slot is DONE; out_data and out_tag SHALL present the lowest-indexed DONE slot.
REQ-030 out_data and out_tag SHALL stay stable while out_valid is high and out_ready is low.
REQ-031 Seed accept and output handshake in the same cycle SHALL both take effect; a slot freed this cycle SHALL NOT be reused until the next cycle.
REQ-032 iters SHALL be unsigned 32-bit; 0xFFFFFFFF SHALL be legal and SHALL NOT wrap.

Reset
REQ-033 On rst: fc=0, sp=0, all slots IDLE, inflight clear, phase_advance=0, Din=0, out_valid=0, seed_ready=0.
REQ-034 The first cycle after reset release SHALL have seed_ready=1.
REQ-035 Reset asserted mid-operation SHALL discard all jobs; R bursts after release SHALL NOT be captured.

Verification
REQ-036 Bench model R = Din+1 delayed per CAP_OFS/LAG; seed words 0..4 = 1..5, iters=1 -> out_data words 2..6, out_tag=0.
REQ-037 Same model, iters=3 -> out_data words 4..8, out_valid one output only.
REQ-038 iters=0, seed 0xA5 pattern -> out_valid next cycle, out_data=seed, Din stays 0, no phase-dependent capture.
REQ-039 Five seeds back-to-back, out_ready=0 -> four accepted (tags 0..3), seed_ready=0 until first output handshake.
REQ-040 rst pulse during slot 2 capture at fc CAP_OFS+2 -> all outputs at reset values; R burst that follows is ignored; out_valid stays 0.
REQ-041 phase_advance period checked 20 cycles over 1000 cycles; Din nonzero only at fc 0..4 of a BUSY slot.

Source files
------------

// File: rtl/quad_iter.sv
// quad_iter: four-slot job scheduler that time-multiplexes iterated hash passes
// over a shared frame-based hash pipeline.
module quad_iter #(
   parameter int CAP_OFS = 8,
   parameter int LAG     = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         seed_valid,
   output logic         seed_ready,
   input  logic [159:0] seed_data,
   input  logic [31:0]  seed_iters,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [159:0] out_data,
   output logic [1:0]   out_tag,
   output logic         phase_advance,
   output logic [31:0]  Din,
   input  logic [31:0]  R
);
   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
   logic [4:0]  fc;
   logic [1:0]  sp;
   logic [1:0]  st [4];
   logic [3:0]  inflight;
   logic [31:0] iters [4];
   logic [31:0] mem [4][5];
   logic        held;
   logic [1:0]  sel_q;
   logic [1:0]  sel, done_low, seed_slot, cap;
   logic        done_hit, seed_hit, issue_win, cap_win, cap_last, seed_acc, out_acc;
   logic [4:0]  cap_k;
   assign issue_win = fc < 5'd5;
   assign cap = sp - 2'(LAG);
   assign cap_win = fc >= 5'(CAP_OFS) && fc <= 5'(CAP_OFS + 4);
   assign cap_last = fc == 5'(CAP_OFS + 4);
   assign cap_k = fc - 5'(CAP_OFS);
   always_comb begin
      seed_hit = 1'b0;
      seed_slot = 2'd0;
      done_hit = 1'b0;
      done_low = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (st[i] == IDLE && !(sp == 2'(i) && issue_win)) begin
            seed_hit = 1'b1;
            seed_slot = 2'(i);
         end
         if (st[i] == DONE) begin
            done_hit = 1'b1;
            done_low = 2'(i);
         end
      end
   end
   // once presented, the selection is frozen until the consumer takes it
   assign sel = held ? sel_q : done_low;
   assign seed_ready = seed_hit & ~rst;
   assign out_valid = done_hit;
   assign out_tag = sel;
   assign out_data = {mem[sel][0], mem[sel][1], mem[sel][2], mem[sel][3], mem[sel][4]};
   assign phase_advance = fc == 5'd18;
   assign Din = (issue_win && st[sp] == BUSY) ? mem[sp][fc[2:0]] : 32'd0;
   assign seed_acc = seed_valid & seed_ready;
   assign out_acc = out_valid & out_ready;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fc <= 5'd0;
         sp <= 2'd0;
         inflight <= 4'd0;
         held <= 1'b0;
         sel_q <= 2'd0;
         for (int i = 0; i < 4; i++) st[i] <= IDLE;
      end else begin
         fc <= fc == 5'd19 ? 5'd0 : fc + 5'd1;
         if (fc == 5'd19) sp <= sp + 2'd1;
         held <= out_valid & ~out_ready;
         sel_q <= sel;
         for (int i = 0; i < 4; i++) begin
            if (fc == 5'd0 && sp == 2'(i) && st[i] == BUSY) inflight[i] <= 1'b1;
            if (cap == 2'(i) && inflight[i] && cap_last) begin
               inflight[i] <= 1'b0;
               if (iters[i] == 32'd1) st[i] <= DONE;
            end
            if (seed_acc && seed_slot == 2'(i)) st[i] <= seed_iters == 32'd0 ? DONE : BUSY;
            if (out_acc && sel == 2'(i)) st[i] <= IDLE;
         end
      end
   end
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (seed_acc && seed_slot == 2'(i)) begin
            iters[i] <= seed_iters;
            for (int k = 0; k < 5; k++) mem[i][k] <= seed_data[159 - 32 * k -: 32];
         end else if (cap == 2'(i) && inflight[i] && cap_win) begin
            mem[i][cap_k[2:0]] <= R;
            if (cap_last) iters[i] <= iters[i] - 32'd1;
         end
      end
   end
endmodule

// File: tb/tb_quad_iter.sv
// tb_quad_iter: directed checks of quad_iter against a Din+1 echo pipeline model.
module tb_quad_iter;
   localparam int CAP_OFS = 8;
   localparam int LAG = 1;
   localparam int D = 20 * LAG + CAP_OFS;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         seed_valid = 1'b0;
   logic         seed_ready;
   logic [159:0] seed_data = '0;
   logic [31:0]  seed_iters = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [159:0] out_data;
   logic [1:0]   out_tag;
   logic         phase_advance;
   logic [31:0]  Din;
   logic [31:0]  R;
   logic [D*32-1:0] pipe = '0;
   logic [4:0]   m_fc;
   logic [1:0]   m_sp;
   int checks = 0;
   int errors = 0;
   int pa = 0;
   quad_iter #(.CAP_OFS(CAP_OFS), .LAG(LAG)) dut (
      .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed_ready(seed_ready),
      .seed_data(seed_data), .seed_iters(seed_iters), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
      .phase_advance(phase_advance), .Din(Din), .R(R)
   );
   always #5 clk = ~clk;
   // external hash pipeline model: each word comes back incremented D cycles later
   always @(posedge clk) pipe <= {pipe[(D-1)*32-1:0], (Din != 32'd0) ? Din + 32'd1 : 32'd0};
   assign R = pipe[D*32-1 -: 32];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_fc <= 5'd0;
         m_sp <= 2'd0;
      end else begin
         m_fc <= m_fc == 5'd19 ? 5'd0 : m_fc + 5'd1;
         if (m_fc == 5'd19) m_sp <= m_sp + 2'd1;
      end
   end
   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   always @(negedge clk) begin
      chk("phase_advance", 160'(phase_advance), 160'(m_fc == 5'd18));
      if (m_fc >= 5'd5) chk("din_outside_window", 160'(Din), 160'd0);
   end
   task automatic wait_fc(input int s, input int f, input int budget, input string tag);
      int n = 0;
      while (n < budget && !((s < 0 || int'(m_sp) == s) && int'(m_fc) == f)) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 160'(n < budget), 160'd1);
   endtask
   task automatic wait_out(input int budget, input string tag);
      int n = 0;
      while (n < budget && !out_valid) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 160'(out_valid), 160'd1);
   endtask
   task automatic offer(input logic [159:0] d, input logic [31:0] it, input logic exp_ready, input string tag);
      seed_valid = 1'b1;
      seed_data = d;
      seed_iters = it;
      #1 chk(tag, 160'(seed_ready), 160'(exp_ready));
      @(negedge clk);
      seed_valid = 1'b0;
   endtask
   task automatic take(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      #1 chk(tag, 160'(out_valid), 160'd0);
   endtask
   initial begin
      repeat (2) @(negedge clk);
      chk("rst_seed_ready", 160'(seed_ready), 160'd0);
      chk("rst_out_valid", 160'(out_valid), 160'd0);
      chk("rst_din", 160'(Din), 160'd0);
      rst = 1'b0;
      #1 chk("first_seed_ready", 160'(seed_ready), 160'd1);
      @(negedge clk);
      // single pass: words 1..5 return as 2..6
      wait_fc(-1, 5, 40, "wait_a");
      offer({32'd1, 32'd2, 32'd3, 32'd4, 32'd5}, 32'd1, 1'b1, "a_accept");
      wait_fc(0, 0, 100, "wait_a_issue");
      for (int k = 0; k < 5; k++) begin
         chk("a_din", 160'(Din), 160'(k + 1));
         @(negedge clk);
      end
      wait_out(100, "a_out_valid");
      chk("a_out_data", out_data, {32'd2, 32'd3, 32'd4, 32'd5, 32'd6});
      chk("a_out_tag", 160'(out_tag), 160'd0);
      take("a_take");
      // three passes: words 1..5 return as 4..8
      wait_fc(-1, 5, 40, "wait_b");
      offer({32'd1, 32'd2, 32'd3, 32'd4, 32'd5}, 32'd3, 1'b1, "b_accept");
      wait_out(500, "b_out_valid");
      chk("b_out_data", out_data, {32'd4, 32'd5, 32'd6, 32'd7, 32'd8});
      chk("b_out_tag", 160'(out_tag), 160'd0);
      take("b_take");
      repeat (100) @(negedge clk);
      chk("b_single_output", 160'(out_valid), 160'd0);
      // zero iterations: immediate done with the seed itself
      wait_fc(-1, 5, 40, "wait_c");
      offer({5{32'hA5A5A5A5}}, 32'd0, 1'b1, "c_accept");
      chk("c_out_valid", 160'(out_valid), 160'd1);
      chk("c_out_data", out_data, {5{32'hA5A5A5A5}});
      chk("c_out_tag", 160'(out_tag), 160'd0);
      for (int k = 0; k < 20; k++) begin
         chk("c_din_zero", 160'(Din), 160'd0);
         chk("c_hold_data", out_data, {5{32'hA5A5A5A5}});
         @(negedge clk);
      end
      take("c_take");
      // five seeds with no consumer: four fit, the fifth waits
      wait_fc(-1, 5, 40, "wait_d");
      seed_iters = 32'd0;
      for (int i = 0; i < 5; i++) begin
         seed_valid = 1'b1;
         seed_data = {5{32'h11111111 * (i + 1)}};
         #1 chk("d_accept", 160'(seed_ready), 160'(i < 4));
         @(negedge clk);
         chk("d_tag_hold", 160'(out_tag), 160'd0);
      end
      repeat (3) begin
         chk("d_full_ready", 160'(seed_ready), 160'd0);
         chk("d_hold_tag", 160'(out_tag), 160'd0);
         chk("d_hold_data", out_data, {5{32'h11111111}});
         @(negedge clk);
      end
      seed_valid = 1'b0;
      out_ready = 1'b1;
      #1 chk("d_same_cycle_ready", 160'(seed_ready), 160'd0);
      @(negedge clk);
      for (int i = 1; i < 4; i++) begin
         #1 chk("d_drain_tag", 160'(out_tag), 160'(i));
         chk("d_drain_data", out_data, {5{32'h11111111 * (i + 1)}});
         if (i == 1) chk("d_freed_ready", 160'(seed_ready), 160'd1);
         @(negedge clk);
      end
      out_ready = 1'b0;
      #1 chk("d_drained", 160'(out_valid), 160'd0);
      // reset in the middle of slot 2's capture
      wait_fc(-1, 5, 40, "wait_e");
      offer({5{32'h01010101}}, 32'd0, 1'b1, "e_accept0");
      offer({5{32'h02020202}}, 32'd0, 1'b1, "e_accept1");
      offer({32'd9, 32'd8, 32'd7, 32'd6, 32'd5}, 32'd1, 1'b1, "e_accept2");
      chk("e_tag", 160'(out_tag), 160'd0);
      wait_fc(2, 0, 100, "wait_e_issue");
      chk("e_issue_din", 160'(Din), 160'd9);
      wait_fc(3, CAP_OFS + 2, 60, "wait_e_cap");
      rst = 1'b1;
      #1 chk("e_rst_out_valid", 160'(out_valid), 160'd0);
      chk("e_rst_seed_ready", 160'(seed_ready), 160'd0);
      chk("e_rst_din", 160'(Din), 160'd0);
      chk("e_rst_phase", 160'(phase_advance), 160'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (100) begin
         @(negedge clk);
         chk("e_no_capture", 160'(out_valid), 160'd0);
      end
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         if (phase_advance) pa++;
      end
      chk("phase_count_1000", 160'(pa), 160'd50);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
